// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 4-digit display scanner.
package display_scan_ctrl_pkg;

  // Two-state scan FSM encoding.
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam int         NUM_DIGITS = 4;

  // Code driven to the 7-segment decoder when a digit is dark.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // One-hot digit enable for a digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot timer: counts cycles within the current BLANK or SHOW phase and
// strobes slot_done on the last cycle of that phase.
module display_scan_ctrl_scan_timer #(
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic is_show,
  output logic slot_done,
  output logic slot_first
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign slot_done  = is_show ? (cnt == SHOW_LAST) : (cnt == BLANK_LAST);
  assign slot_first = (cnt == '0);

  // Cycle counter, restarted at the end of every phase.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset)          cnt <= '0;
    else if (slot_done) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with anti-ghost blanking, per-digit
// blink, hour-tens leading-zero suppression and a frame-synchronous shadow.
// Outputs are a registered view of the scan position held in the FSM, so
// they trail the internal position by one cycle; the first cycle after reset
// release is therefore the first BLANK cycle of digit 0.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        upd_req,
  output logic        upd_ack,
  input  logic [3:0]  blink_mask,
  input  logic        lz_en,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en,
  output logic        frame_start
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [0:0]    state;
  logic [1:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [15:0]   shadow;

  logic          slot_done;
  logic          slot_first;

  logic          at_frame_start;
  logic          load;
  logic [15:0]   shadow_eff;
  logic [3:0]    cur_digit;
  logic          suppress;

  display_scan_ctrl_scan_timer #(
    .SHOW_CYCLES  (SHOW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clk        (clk),
    .reset      (reset),
    .is_show    (state == ST_SHOW),
    .slot_done  (slot_done),
    .slot_first (slot_first)
  );

  // Scan FSM: BLANK -> SHOW -> BLANK of the next digit, wrapping 3 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      idx   <= 2'd0;
    end else if (slot_done) begin
      if (state == ST_BLANK) begin
        state <= ST_SHOW;
      end else begin
        state <= ST_BLANK;
        idx   <= idx + 2'd1;
      end
    end
  end

  // Frame counter and blink phase, advanced when the last SHOW slot ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (slot_done && state == ST_SHOW && idx == 2'd3) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + 1'b1;
      end
    end
  end

  // Digit selection and suppression for the position being registered out.
  // A load in the frame-start cycle bypasses the shadow so the new value is
  // visible from the very first cycle of the frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    at_frame_start = 1'b0;
    load           = 1'b0;
    shadow_eff     = shadow;
    cur_digit      = 4'h0;
    suppress       = 1'b0;

    at_frame_start = (state == ST_BLANK) && (idx == 2'd0) && slot_first;
    load           = at_frame_start && upd_req;
    if (load) shadow_eff = digits_in;
    cur_digit      = shadow_eff[{idx, 2'b00} +: 4];
    suppress       = (blink_phase && blink_mask[idx]) ||
                     ((idx == 2'd3) && lz_en && (shadow_eff[15:12] == 4'h0));
  end

  // Shadow register and registered display/handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: the shadow is a 16-bit register, not a memory array, so it is
    // reset to a defined all-zero display like the rest of the state.
    if (reset) begin
      shadow      <= 16'h0000;
      bcd_out     <= BLANK_CODE;
      digit_en    <= 4'b0000;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (load) shadow <= digits_in;
      bcd_out     <= suppress ? BLANK_CODE : cur_digit;
      digit_en    <= (state == ST_SHOW && !suppress) ? digit_onehot(idx) : 4'b0000;
      upd_ack     <= load;
      frame_start <= at_frame_start;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a position-arithmetic model of
// the scan sequence is compared against the DUT every cycle, plus literal
// expectations at known frame positions.
module tb_display_scan_ctrl;

  localparam int SC    = 4;
  localparam int BC    = 1;
  localparam int BF    = 2;
  localparam int SLOT  = SC + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic        upd_req;
  logic        upd_ack;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic        frame_start;

  display_scan_ctrl #(
    .SHOW_CYCLES  (SC),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .blink_mask  (blink_mask),
    .lz_en       (lz_en),
    .bcd_out     (bcd_out),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: t counts cycles since reset release (0 = first frame start).
  int          t;
  int          cur_pos;
  logic [15:0] m_shadow;
  logic [3:0]  e_bcd;
  logic [3:0]  e_en;
  logic        e_ack;
  logic        e_fs;

  // Log of the first frame after a reset, for literal checks.
  logic [3:0]  log_bcd [0:FRAME];
  logic [3:0]  log_en  [0:FRAME];
  logic        log_fs  [0:FRAME];
  logic        log_ack [0:FRAME];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the cycle that the current inputs will produce.
  task automatic model_cycle();
    int pos, f, idx;
    bit show, phase, load, sup;
    if (reset) begin
      e_bcd = 4'hF; e_en = 4'b0000; e_ack = 1'b0; e_fs = 1'b0;
      m_shadow = 16'h0000;
      t = 0;
      cur_pos = -1;
    end else begin
      pos   = t % FRAME;
      f     = t / FRAME;
      idx   = pos / SLOT;
      show  = (pos % SLOT) >= BC;
      phase = ((f / BF) % 2) == 1;
      load  = (pos == 0) && upd_req;
      if (load) m_shadow = digits_in;
      sup   = (phase && blink_mask[idx]) ||
              (idx == 3 && lz_en && m_shadow[15:12] == 4'h0);
      e_bcd = sup ? 4'hF : m_shadow[idx*4 +: 4];
      e_en  = (show && !sup) ? 4'(1 << idx) : 4'b0000;
      e_ack = load;
      e_fs  = (pos == 0);
      cur_pos = pos;
      t++;
    end
  endtask

  // Apply current inputs for one clock, then compare against the model.
  task automatic step();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    check("bcd_out",     {12'h0, bcd_out},  {12'h0, e_bcd});
    check("digit_en",    {12'h0, digit_en}, {12'h0, e_en});
    check("upd_ack",     {15'h0, upd_ack},  {15'h0, e_ack});
    check("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
    check("onehot0",     {15'h0, ($countones(digit_en) <= 1)}, 16'h1);
  endtask

  task automatic run_to(input int p);
    int budget;
    budget = 2 * FRAME + 5;
    do begin
      step();
      budget--;
    end while (cur_pos != p && budget > 0);
    if (cur_pos != p) begin
      miscompares++;
      $display("FAIL run_to timeout: position %0d, expected %0d", cur_pos, p);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    digits_in  = 16'h0000;
    upd_req    = 1'b0;
    blink_mask = 4'b0000;
    lz_en      = 1'b0;

    // Reset, then load 1234 on the first frame start.
    do_reset(2);
    check("reset_bcd", {12'h0, bcd_out}, 16'h000F);
    check("reset_en",  {12'h0, digit_en}, 16'h0000);
    upd_req   = 1'b1;
    digits_in = 16'h1234;
    for (int i = 0; i <= FRAME; i++) begin
      step();
      log_bcd[i] = bcd_out; log_en[i] = digit_en;
      log_fs[i]  = frame_start; log_ack[i] = upd_ack;
      upd_req = 1'b0;
    end
    check("c0_fs",   {15'h0, log_fs[0]},  16'h1);
    check("c0_ack",  {15'h0, log_ack[0]}, 16'h1);
    check("c0_bcd",  {12'h0, log_bcd[0]}, 16'h4);
    check("c0_en",   {12'h0, log_en[0]},  16'h0);
    check("c1_en",   {12'h0, log_en[1]},  16'h1);
    check("c4_en",   {12'h0, log_en[4]},  16'h1);
    check("c5_en",   {12'h0, log_en[5]},  16'h0);
    check("c6_bcd",  {12'h0, log_bcd[6]}, 16'h3);
    check("c6_en",   {12'h0, log_en[6]},  16'h2);
    check("c11_bcd", {12'h0, log_bcd[11]}, 16'h2);
    check("c11_en",  {12'h0, log_en[11]}, 16'h4);
    check("c16_bcd", {12'h0, log_bcd[16]}, 16'h1);
    check("c16_en",  {12'h0, log_en[16]}, 16'h8);
    check("c1_fs",   {15'h0, log_fs[1]},  16'h0);
    check("c20_fs",  {15'h0, log_fs[FRAME]}, 16'h1);
    check("c20_ack", {15'h0, log_ack[FRAME]}, 16'h0);

    // Leading-zero suppression of digit 3.
    upd_req   = 1'b1;
    digits_in = 16'h0945;
    lz_en     = 1'b1;
    run_to(0);
    check("lz_ack", {15'h0, upd_ack}, 16'h1);
    upd_req = 1'b0;
    run_to(16);
    check("lz_en_dark",  {12'h0, digit_en}, 16'h0);
    check("lz_bcd_dark", {12'h0, bcd_out},  16'hF);
    lz_en = 1'b0;
    run_to(16);
    check("lz_off_en",  {12'h0, digit_en}, 16'h8);
    check("lz_off_bcd", {12'h0, bcd_out},  16'h0);

    // Blink of digits 0 and 1 with a clean frame count.
    do_reset(1);
    blink_mask = 4'b0011;
    for (int f = 0; f < 6; f++) begin
      run_to(1);
      check("blink_d0_en",  {12'h0, digit_en}, (f == 2 || f == 3) ? 16'h0 : 16'h1);
      check("blink_d0_bcd", {12'h0, bcd_out},  (f == 2 || f == 3) ? 16'hF : 16'h0);
      run_to(11);
      check("blink_d2_en",  {12'h0, digit_en}, 16'h4);
    end
    blink_mask = 4'b0000;

    // Mid-frame update request is ignored.
    upd_req   = 1'b1;
    digits_in = 16'h5678;
    run_to(0);
    upd_req = 1'b0;
    run_to(16);
    digits_in = 16'h9999;
    upd_req   = 1'b1;
    step();
    upd_req = 1'b0;
    run_to(0);
    check("mid_no_ack", {15'h0, upd_ack}, 16'h0);
    run_to(1);
    check("mid_keep_bcd", {12'h0, bcd_out}, 16'h8);

    // Reset during SHOW of digit 2.
    run_to(12);
    reset = 1'b1;
    step();
    check("rst_mid_bcd", {12'h0, bcd_out},  16'hF);
    check("rst_mid_en",  {12'h0, digit_en}, 16'h0);
    check("rst_mid_fs",  {15'h0, frame_start}, 16'h0);
    reset = 1'b0;
    step();
    check("rst_rel_fs",  {15'h0, frame_start}, 16'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      upd_req   = $urandom_range(0, 1);
      digits_in = 16'($urandom);
      if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom);
      lz_en     = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
